// File: rtl/pp_sequencer.sv
// Pulse-accumulation sequencer: clear -> N trigger/capture bursts -> post-process -> host readout.
// Moore outputs, one-cycle state latency; start sampled only in IDLE, abort/rst force IDLE next cycle.
module pp_sequencer #(
  parameter int CNT_W  = 16,
  parameter int TO_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic             continuous,
  input  logic             trigger_in,
  input  logic             data_valid_in,
  input  logic             pp_done,
  input  logic             rd_done,
  output logic             acc_clear,
  output logic             acc_en,
  output logic             first_pulse,
  output logic             pp_ctrl,
  output logic             data_ready,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             err_overrun,
  output logic             err_timeout,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLEAR     = 3'd1;
  localparam logic [2:0] S_WAIT_TRIG = 3'd2;
  localparam logic [2:0] S_CAPTURE   = 3'd3;
  localparam logic [2:0] S_POST      = 3'd4;
  localparam logic [2:0] S_READY     = 3'd5;

  localparam int              WD_W    = $clog2(TO_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);

  logic             trig_d;
  logic             dv_d;
  logic [CNT_W-1:0] n_lat;
  logic             cont_lat;
  logic [WD_W-1:0]  wd;
  logic             trig_rise;
  logic             dv_fall;
  logic [CNT_W-1:0] cnt_nxt;

  assign trig_rise = trigger_in & ~trig_d;
  assign dv_fall   = ~data_valid_in & dv_d;
  assign cnt_nxt   = pulse_cnt + 1'b1;

  assign acc_clear   = (state == S_CLEAR);
  assign acc_en      = (state == S_CAPTURE);
  assign pp_ctrl     = (state == S_POST);
  assign data_ready  = (state == S_READY);
  assign busy        = (state != S_IDLE);
  assign first_pulse = acc_en & (pulse_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      trig_d      <= 1'b0;
      dv_d        <= 1'b0;
      n_lat       <= CNT_W'(1);
      cont_lat    <= 1'b0;
      wd          <= '0;
      pulse_cnt   <= '0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      trig_d <= trigger_in;
      dv_d   <= data_valid_in;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              n_lat       <= (num_pulses == '0) ? CNT_W'(1) : num_pulses;
              cont_lat    <= continuous;
              err_overrun <= 1'b0;
              err_timeout <= 1'b0;
              pulse_cnt   <= '0;
              state       <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            pulse_cnt <= '0;
            state     <= S_WAIT_TRIG;
          end
          S_WAIT_TRIG: begin
            wd <= '0;
            if (trig_rise) state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            // A trigger edge here is an overrun; it is flagged but never restarts capture.
            if (trig_rise) err_overrun <= 1'b1;
            if (dv_fall) begin
              pulse_cnt <= cnt_nxt;
              wd        <= '0;
              state     <= (cnt_nxt == n_lat) ? S_POST : S_WAIT_TRIG;
            end else if (data_valid_in) begin
              wd <= '0;
            end else if (wd == WD_LAST) begin
              err_timeout <= 1'b1;
              wd          <= '0;
              state       <= S_IDLE;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          S_POST: begin
            if (pp_done) state <= S_READY;
          end
          S_READY: begin
            if (rd_done) begin
              if (cont_lat) begin
                pulse_cnt <= '0;
                state     <= S_CLEAR;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pp_sequencer.sv
// Directed bench for pp_sequencer; inputs change 1 time unit after each rising edge, outputs read there.
module tb_pp_sequencer;
  localparam int CNT_W  = 16;
  localparam int TO_CYC = 16;

  logic clk = 1'b0;
  logic rst, start, abort, continuous, trigger_in, data_valid_in, pp_done, rd_done;
  logic [CNT_W-1:0] num_pulses;
  logic acc_clear, acc_en, first_pulse, pp_ctrl, data_ready, busy, err_overrun, err_timeout;
  logic [CNT_W-1:0] pulse_cnt;
  logic [2:0] state;

  int tests = 0;
  int failed = 0;
  int clr_cycles;
  int fp_cycles;
  logic [2:0] trace[$];

  pp_sequencer #(.CNT_W(CNT_W), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_pulses(num_pulses),
    .continuous(continuous), .trigger_in(trigger_in), .data_valid_in(data_valid_in),
    .pp_done(pp_done), .rd_done(rd_done), .acc_clear(acc_clear), .acc_en(acc_en),
    .first_pulse(first_pulse), .pp_ctrl(pp_ctrl), .data_ready(data_ready), .busy(busy),
    .pulse_cnt(pulse_cnt), .err_overrun(err_overrun), .err_timeout(err_timeout), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc_clear) clr_cycles++;
    if (first_pulse) fp_cycles++;
    if (trace.size() == 0 || trace[$] != state) trace.push_back(state);
  endtask

  task automatic obs_reset();
    trace.delete();
    trace.push_back(state);
    clr_cycles = 0;
    fp_cycles  = 0;
  endtask

  // One laser shot: trigger edge, one cycle of valid window, then the closing fall.
  task automatic burst();
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    tick();
  endtask

  task automatic begin_run(input logic [CNT_W-1:0] n, input logic cont);
    num_pulses = n;
    continuous = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (state !== 3'd0 || pulse_cnt !== '0) begin
      failed++;
      $display("FAIL reset_state: state=%0d pulse_cnt=%0d, expected 0 and 0", state, pulse_cnt);
    end
    tests++;
    if ({acc_clear, acc_en, first_pulse, pp_ctrl, data_ready, busy, err_overrun, err_timeout} !== 8'h00) begin
      failed++;
      $display("FAIL reset_outputs: got %b, expected 00000000",
               {acc_clear, acc_en, first_pulse, pp_ctrl, data_ready, busy, err_overrun, err_timeout});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int exp_seq[11] = '{0, 1, 2, 3, 2, 3, 2, 3, 4, 5, 0};
    obs_reset();
    num_pulses = 3;
    continuous = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (state !== 3'd1 || acc_clear !== 1'b1 || busy !== 1'b1) begin
      failed++;
      $display("FAIL basic_clear: state=%0d acc_clear=%0b busy=%0b, expected 1 1 1", state, acc_clear, busy);
    end
    tick();
    tests++;
    if (state !== 3'd2 || acc_clear !== 1'b0) begin
      failed++;
      $display("FAIL basic_wait: state=%0d acc_clear=%0b, expected 2 0", state, acc_clear);
    end
    burst();
    tests++;
    if (fp_cycles !== 2 || pulse_cnt !== 16'd1) begin
      failed++;
      $display("FAIL basic_burst1: fp_cycles=%0d pulse_cnt=%0d, expected 2 1", fp_cycles, pulse_cnt);
    end
    burst();
    burst();
    tests++;
    if (state !== 3'd4 || pp_ctrl !== 1'b1 || acc_en !== 1'b0) begin
      failed++;
      $display("FAIL basic_post: state=%0d pp_ctrl=%0b acc_en=%0b, expected 4 1 0", state, pp_ctrl, acc_en);
    end
    pp_done = 1'b1;
    tick();
    pp_done = 1'b0;
    tests++;
    if (state !== 3'd5 || data_ready !== 1'b1 || pp_ctrl !== 1'b0) begin
      failed++;
      $display("FAIL basic_ready: state=%0d data_ready=%0b pp_ctrl=%0b, expected 5 1 0", state, data_ready, pp_ctrl);
    end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tests++;
    if (state !== 3'd0 || busy !== 1'b0 || pulse_cnt !== 16'd3) begin
      failed++;
      $display("FAIL basic_end: state=%0d busy=%0b pulse_cnt=%0d, expected 0 0 3", state, busy, pulse_cnt);
    end
    tests++;
    if (clr_cycles !== 1 || fp_cycles !== 2) begin
      failed++;
      $display("FAIL basic_pulses: clr_cycles=%0d fp_cycles=%0d, expected 1 2", clr_cycles, fp_cycles);
    end
    tests++;
    if (trace.size() !== 11) begin
      failed++;
      $display("FAIL basic_trace_len: got %0d states, expected 11", trace.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        tests++;
        if (trace[i] !== 3'(exp_seq[i])) begin
          failed++;
          $display("FAIL basic_trace[%0d]: got %0d, expected %0d", i, trace[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_zero_pulses();
    begin_run(16'd0, 1'b0);
    burst();
    tests++;
    if (state !== 3'd4 || pulse_cnt !== 16'd1) begin
      failed++;
      $display("FAIL zero_pulses: state=%0d pulse_cnt=%0d, expected 4 1", state, pulse_cnt);
    end
    pp_done = 1'b1;
    tick();
    pp_done = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tests++;
    if (state !== 3'd0) begin
      failed++;
      $display("FAIL zero_pulses_end: state=%0d, expected 0", state);
    end
  endtask

  task automatic test_overrun();
    begin_run(16'd2, 1'b0);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    data_valid_in = 1'b1;
    tick();
    // Fall and a fresh trigger edge on the same cycle.
    trigger_in = 1'b1;
    data_valid_in = 1'b0;
    tick();
    tests++;
    if (err_overrun !== 1'b1 || pulse_cnt !== 16'd1 || state !== 3'd2) begin
      failed++;
      $display("FAIL overrun_simul: err=%0b pulse_cnt=%0d state=%0d, expected 1 1 2", err_overrun, pulse_cnt, state);
    end
    trigger_in = 1'b0;
    tick();
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    data_valid_in = 1'b1;
    tick();
    trigger_in = 1'b1;
    tick();
    tests++;
    if (state !== 3'd3 || pulse_cnt !== 16'd1) begin
      failed++;
      $display("FAIL overrun_mid: state=%0d pulse_cnt=%0d, expected 3 1", state, pulse_cnt);
    end
    trigger_in = 1'b0;
    data_valid_in = 1'b0;
    tick();
    tests++;
    if (state !== 3'd4 || pulse_cnt !== 16'd2 || err_overrun !== 1'b1) begin
      failed++;
      $display("FAIL overrun_post: state=%0d pulse_cnt=%0d err=%0b, expected 4 2 1", state, pulse_cnt, err_overrun);
    end
    pp_done = 1'b1;
    tick();
    pp_done = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tests++;
    if (state !== 3'd0 || err_overrun !== 1'b1) begin
      failed++;
      $display("FAIL overrun_sticky: state=%0d err=%0b, expected 0 1", state, err_overrun);
    end
    num_pulses = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (err_overrun !== 1'b0 || state !== 3'd1) begin
      failed++;
      $display("FAIL overrun_clear: err=%0b state=%0d, expected 0 1", err_overrun, state);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_timeout();
    begin_run(16'd1, 1'b0);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    for (int i = 0; i < TO_CYC - 1; i++) tick();
    tests++;
    if (state !== 3'd3 || err_timeout !== 1'b0) begin
      failed++;
      $display("FAIL timeout_early: state=%0d err=%0b, expected 3 0", state, err_timeout);
    end
    tick();
    tests++;
    if (state !== 3'd0 || err_timeout !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL timeout_fire: state=%0d err=%0b busy=%0b, expected 0 1 0", state, err_timeout, busy);
    end
  endtask

  task automatic test_continuous();
    obs_reset();
    begin_run(16'd2, 1'b1);
    burst();
    burst();
    pp_done = 1'b1;
    tick();
    pp_done = 1'b0;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tests++;
    if (state !== 3'd1 || acc_clear !== 1'b1 || clr_cycles !== 2) begin
      failed++;
      $display("FAIL cont_reclear: state=%0d acc_clear=%0b clr_cycles=%0d, expected 1 1 2", state, acc_clear, clr_cycles);
    end
    tick();
    tests++;
    if (state !== 3'd2 || pulse_cnt !== 16'd0) begin
      failed++;
      $display("FAIL cont_restart: state=%0d pulse_cnt=%0d, expected 2 0", state, pulse_cnt);
    end
    burst();
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if (state !== 3'd0 || busy !== 1'b0 || pulse_cnt !== 16'd1) begin
      failed++;
      $display("FAIL cont_abort: state=%0d busy=%0b pulse_cnt=%0d, expected 0 0 1", state, busy, pulse_cnt);
    end
  endtask

  task automatic test_reset_in_post();
    begin_run(16'd1, 1'b0);
    burst();
    rst = 1'b1;
    pp_done = 1'b1;
    tick();
    rst = 1'b0;
    pp_done = 1'b0;
    tests++;
    if (state !== 3'd0 || data_ready !== 1'b0 || pulse_cnt !== 16'd0) begin
      failed++;
      $display("FAIL rst_post: state=%0d data_ready=%0b pulse_cnt=%0d, expected 0 0 0", state, data_ready, pulse_cnt);
    end
    tick();
    tests++;
    if (state !== 3'd0 || data_ready !== 1'b0) begin
      failed++;
      $display("FAIL rst_post_after: state=%0d data_ready=%0b, expected 0 0", state, data_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    continuous = 1'b0;
    trigger_in = 1'b0;
    data_valid_in = 1'b0;
    pp_done = 1'b0;
    rd_done = 1'b0;
    num_pulses = '0;
    clr_cycles = 0;
    fp_cycles = 0;
    test_reset();
    test_basic();
    test_zero_pulses();
    test_overrun();
    test_timeout();
    test_continuous();
    test_reset_in_post();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
